row_sync_arbiter: RTL and testbench

- Row-level responder for the core sync interface. Each core drives `o_core_req`, `o_core_locked`, `o_URAM_*`; this block returns `i_core_grant` and `i_uram_emptied`.
- Grants exclusive write ownership of the shared row URAM to one core at a time, round-robin, and registers the owner's URAM port onto the shared URAM.
- Implements the row barrier: all cores locked → hand URAM to host for draining → broadcast emptied → release.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/rr_priority_picker.sv | 28 ++
 rtl/row_sync_arbiter.sv | 119 +++++++++++
 tb/tb_row_sync_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and defaults for the row sync arbiter.
// Holds the barrier/ownership state encoding used by the row FSM.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    DRAIN   = 2'd2,
    RELEASE = 2'd3
  } row_sync_state_t;

  localparam int ROW_NUM_CORES = 8;
  localparam int ROW_ADDR_W    = 12;
  localparam int ROW_DATA_W    = 32;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set req bit at or after ptr,
// scanning upward with wrap-around.
module rr_priority_picker #(
  parameter int NUM_CORES = 8,
  localparam int IDX_W = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  // Scan from the farthest offset down so the nearest wins.
  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_CORES;
      if (req[IDX_W'(j)]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/row_sync_arbiter.sv
// Row-level URAM ownership arbiter and barrier responder:
// round-robin core grants, host drain handoff, registered URAM mux.
module row_sync_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_CORES = ROW_NUM_CORES,
  parameter int ADDR_W    = ROW_ADDR_W,
  parameter int DATA_W    = ROW_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        i_core_req,
  input  logic [NUM_CORES-1:0]        i_core_locked,
  output logic [NUM_CORES-1:0]        o_core_grant,
  output logic                        o_uram_emptied,
  input  logic [NUM_CORES-1:0]        i_core_uram_en,
  input  logic [NUM_CORES-1:0]        i_core_uram_wr_en,
  input  logic [NUM_CORES*ADDR_W-1:0] i_core_uram_addr,
  input  logic [NUM_CORES*DATA_W-1:0] i_core_uram_wr_data,
  output logic                        o_row_full,
  input  logic                        i_host_uram_en,
  input  logic [ADDR_W-1:0]           i_host_uram_addr,
  input  logic                        i_host_drained,
  output logic                        o_uram_en,
  output logic                        o_uram_wr_en,
  output logic [ADDR_W-1:0]           o_uram_addr,
  output logic [DATA_W-1:0]           o_uram_wr_data
);

  localparam int IDX_W = $clog2(NUM_CORES);

  row_sync_state_t  state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             all_locked;
  logic             none_locked;

  assign all_locked  = &i_core_locked;
  assign none_locked = ~|i_core_locked;

  rr_priority_picker #(
    .NUM_CORES(NUM_CORES)
  ) u_picker (
    .req  (i_core_req),
    .ptr  (rr_ptr),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Barrier wins over any pending request.
          if (all_locked) begin
            state <= DRAIN;
          end else if (pick_valid) begin
            state <= GRANT;
            owner <= pick_idx;
          end
        end
        GRANT: begin
          if (!i_core_req[owner]) begin
            state  <= IDLE;
            rr_ptr <= (owner == IDX_W'(NUM_CORES - 1))
                      ? '0 : owner + 1'b1;
          end
        end
        DRAIN: begin
          if (i_host_drained) state <= RELEASE;
        end
        RELEASE: begin
          if (none_locked) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_core_grant = '0;
    if (state == GRANT) o_core_grant[owner] = 1'b1;
  end

  assign o_row_full     = (state == DRAIN);
  assign o_uram_emptied = (state == RELEASE);

  // Only the current owner (or the host while draining) reaches URAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_uram_en      <= 1'b0;
      o_uram_wr_en   <= 1'b0;
      o_uram_addr    <= '0;
      o_uram_wr_data <= '0;
    end else if (state == GRANT) begin
      o_uram_en      <= i_core_uram_en[owner];
      o_uram_wr_en   <= i_core_uram_wr_en[owner];
      o_uram_addr    <= i_core_uram_addr[int'(owner)*ADDR_W +: ADDR_W];
      o_uram_wr_data <= i_core_uram_wr_data[int'(owner)*DATA_W +: DATA_W];
    end else if (state == DRAIN) begin
      o_uram_en      <= i_host_uram_en;
      o_uram_wr_en   <= 1'b0;
      o_uram_addr    <= i_host_uram_addr;
      o_uram_wr_data <= '0;
    end else begin
      o_uram_en      <= 1'b0;
      o_uram_wr_en   <= 1'b0;
      o_uram_addr    <= '0;
      o_uram_wr_data <= '0;
    end
  end

endmodule

// File: tb/tb_row_sync_arbiter.sv
// Self-checking bench for row_sync_arbiter: directed steps plus
// randomized traffic against a per-cycle behavioural model.
module tb_row_sync_arbiter;

  localparam int N  = 8;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req, locked, grant;
  logic            emptied, row_full;
  logic [N-1:0]    uen, uwr;
  logic [N*AW-1:0] uaddr;
  logic [N*DW-1:0] udata;
  logic            hen, drained;
  logic [AW-1:0]   haddr;
  logic            o_en, o_wr;
  logic [AW-1:0]   o_addr;
  logic [DW-1:0]   o_data;

  row_sync_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                (clk),
    .reset              (reset),
    .i_core_req         (req),
    .i_core_locked      (locked),
    .o_core_grant       (grant),
    .o_uram_emptied     (emptied),
    .i_core_uram_en     (uen),
    .i_core_uram_wr_en  (uwr),
    .i_core_uram_addr   (uaddr),
    .i_core_uram_wr_data(udata),
    .o_row_full         (row_full),
    .i_host_uram_en     (hen),
    .i_host_uram_addr   (haddr),
    .i_host_drained     (drained),
    .o_uram_en          (o_en),
    .o_uram_wr_en       (o_wr),
    .o_uram_addr        (o_addr),
    .o_uram_wr_data     (o_data)
  );

  int errors = 0;
  int checks = 0;

  // Model: phase 0 free, 1 owned by core `owner`, 2 host draining, 3 emptied.
  int            phase, owner, next_first;
  logic          m_en, m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; owner = -1; next_first = 0;
    m_en = 0; m_wr = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic cyc();
    int            np, no, nf;
    logic          ne, nw;
    logic [AW-1:0] na;
    logic [DW-1:0] nd;
    logic [N-1:0]  eg;
    bit            found;
    np = phase; no = owner; nf = next_first;
    ne = 0; nw = 0; na = '0; nd = '0; found = 0;
    if (phase == 1) begin
      ne = uen[owner]; nw = uwr[owner];
      na = uaddr[owner*AW +: AW]; nd = udata[owner*DW +: DW];
    end else if (phase == 2) begin
      ne = hen; na = haddr;
    end
    if (phase == 0) begin
      if (locked == '1) np = 2;
      else for (int i = 0; i < N; i++) begin
        int c;
        c = (next_first + i) % N;
        if (!found && req[c]) begin found = 1; no = c; np = 1; end
      end
    end else if (phase == 1) begin
      if (!req[owner]) begin np = 0; nf = (owner + 1) % N; no = -1; end
    end else if (phase == 2) begin
      if (drained) np = 3;
    end else if (locked == '0) np = 0;
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else begin
      phase = np; owner = no; next_first = nf;
      m_en = ne; m_wr = nw; m_addr = na; m_data = nd;
    end
    eg = '0;
    if (phase == 1) eg[owner] = 1'b1;
    chk("grant", 64'(grant), 64'(eg));
    chk("row_full", 64'(row_full), 64'(phase == 2));
    chk("emptied", 64'(emptied), 64'(phase == 3));
    chk("uram_en", 64'(o_en), 64'(m_en));
    chk("uram_wr_en", 64'(o_wr), 64'(m_wr));
    chk("uram_addr", 64'(o_addr), 64'(m_addr));
    chk("uram_wr_data", 64'(o_data), 64'(m_data));
  endtask

  task automatic do_reset();
    reset = 1; cyc(); reset = 0;
  endtask

  initial begin
    reset = 1; req = '0; locked = '0; uen = '0; uwr = '0;
    uaddr = '0; udata = '0; hen = 0; haddr = '0; drained = 0;
    model_reset();
    cyc(); cyc(); reset = 0;
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_uram_en", 64'(o_en), 64'h0);

    // Round-robin basics
    req = 8'h05; cyc();
    chk("rr_first", 64'(grant), 64'h01);
    cyc();
    req = 8'h04; cyc();
    chk("rr_gap", 64'(grant), 64'h00);
    cyc();
    chk("rr_next", 64'(grant), 64'h04);
    req = 8'h00; cyc();

    // Datapath isolation: core 3 owns, core 5 drives garbage
    req = 8'h08; cyc();
    chk("core3_grant", 64'(grant), 64'h08);
    uen = 8'h28; uwr = 8'h28;
    uaddr[3*AW +: AW] = 12'h0A5; udata[3*DW +: DW] = 32'hDEADBEEF;
    uaddr[5*AW +: AW] = 12'hFFF; udata[5*DW +: DW] = 32'h12345678;
    cyc();
    chk("dp_en", 64'(o_en), 64'h1);
    chk("dp_wr", 64'(o_wr), 64'h1);
    chk("dp_addr", 64'(o_addr), 64'h0A5);
    chk("dp_data", 64'(o_data), 64'hDEADBEEF);
    req = 8'h00; cyc(); uen = '0; uwr = '0; cyc();

    // Full rotation, each owner holds two cycles
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("rot_grant", 64'(grant), 64'(1) << (k % N));
      cyc();
      req = 8'hFF & ~(8'(1) << (k % N));
      cyc();
      chk("rot_gap", 64'(grant), 64'h0);
      req = 8'hFF;
    end
    req = '0; cyc(); cyc();

    // Barrier with pending request
    do_reset();
    req = 8'h10; locked = 8'hFF;
    uen = 8'h10; uwr = 8'h10; udata[4*DW +: DW] = 32'hBAD0BAD0;
    cyc();
    chk("drain_full", 64'(row_full), 64'h1);
    chk("drain_nogrant", 64'(grant), 64'h0);
    hen = 1; haddr = 12'h010; cyc();
    chk("host_en", 64'(o_en), 64'h1);
    chk("host_addr", 64'(o_addr), 64'h010);
    chk("host_wr", 64'(o_wr), 64'h0);
    drained = 1; cyc(); drained = 0; hen = 0;
    chk("release_emptied", 64'(emptied), 64'h1);
    chk("release_full", 64'(row_full), 64'h0);
    cyc(); cyc();
    locked = 8'h00; cyc();
    chk("idle_emptied", 64'(emptied), 64'h0);
    cyc();
    chk("post_barrier", 64'(grant), 64'h10);
    uen = '0; uwr = '0; req = '0; cyc(); cyc();

    // Stray drained pulses
    drained = 1; cyc(); drained = 0;
    chk("stray_idle", 64'(row_full | emptied), 64'h0);
    req = 8'h02; cyc(); drained = 1; cyc(); drained = 0;
    chk("stray_grant", 64'(grant), 64'h02);

    // Reset mid-GRANT and mid-DRAIN; pointer returns to 0
    do_reset();
    chk("rst_grant", 64'(grant), 64'h0);
    req = '0; locked = 8'hFF; cyc(); cyc();
    do_reset();
    chk("rst_drain", 64'(row_full), 64'h0);
    locked = '0; req = 8'hFF; cyc();
    chk("rst_ptr", 64'(grant), 64'h01);
    req = '0; cyc(); cyc();

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      int r;
      req = 8'($urandom);
      r = $urandom_range(0, 5);
      locked = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
      uen = 8'($urandom); uwr = 8'($urandom);
      for (int c = 0; c < N; c++) begin
        uaddr[c*AW +: AW] = AW'($urandom);
        udata[c*DW +: DW] = $urandom;
      end
      hen = 1'($urandom); haddr = AW'($urandom);
      drained = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 59) == 0);
      cyc();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
